// File: rtl/sync_ram.sv
`timescale 1ns/1ps
// Single-port synchronous RAM with write-first read port and a synchronous clear of every word.
// Latency: one cycle from addr/we/din to dout; a write is visible on dout in the same edge.
// Backpressure: none; accepts one read or write every cycle with no stall.
module sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage is built from flops so that reset can clear every word in one edge.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    // Next-state: a write updates the addressed word and forwards din to dout; a read only loads dout.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        dout_d = mem_q[addr];
        if (we) begin
            mem_d[addr] = din;
            dout_d      = din;
        end
    end

    // State update; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            dout_q <= dout_d;
        end
    end

    // dout comes straight from a register, so no input reaches it combinationally.
    assign dout = dout_q;

endmodule

// File: tb/tb_sync_ram.sv
`timescale 1ns/1ps
module tb_sync_ram;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int n_checks;
    int n_fails;

    // Reference model: plain array of words plus the expected output register.
    logic [7:0] m_mem [16];
    logic [7:0] m_dout;

    sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, applying the memory rules to the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_dout = 8'h00;
        end else if (we) begin
            m_mem[addr] = din;
            m_dout      = din;
        end else begin
            m_dout = m_mem[addr];
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        rst  = r;
        we   = w;
        addr = a;
        din  = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        tick();
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_dout: got %02h expected 00", dout);
        end
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, a[3:0], 8'hEE);
            tick();
            n_checks++;
            if (dout !== 8'h00) begin
                n_fails++;
                $display("FAIL reset_read_addr%0d: got %02h expected 00", a, dout);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        tick();
        tick();
        drive(1'b0, 1'b1, 4'd2, 8'hA5);
        tick();
        drive(1'b0, 1'b1, 4'd5, 8'h3C);
        tick();
        drive(1'b0, 1'b0, 4'd2, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'hA5) begin
            n_fails++;
            $display("FAIL basic_read_addr2: got %02h expected A5", dout);
        end
        drive(1'b0, 1'b0, 4'd5, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h3C) begin
            n_fails++;
            $display("FAIL basic_read_addr5: got %02h expected 3C", dout);
        end
    endtask

    task automatic test_write_through();
        drive(1'b0, 1'b1, 4'd7, 8'h5A);
        tick();
        n_checks++;
        if (dout !== 8'h5A) begin
            n_fails++;
            $display("FAIL write_through: got %02h expected 5A", dout);
        end
        drive(1'b0, 1'b0, 4'd7, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h5A) begin
            n_fails++;
            $display("FAIL read_after_write: got %02h expected 5A", dout);
        end
    endtask

    task automatic test_boundaries();
        drive(1'b0, 1'b1, 4'd0, 8'h11);
        tick();
        drive(1'b0, 1'b1, 4'd15, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 4'd15, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'hFF) begin
            n_fails++;
            $display("FAIL bound_addr15: got %02h expected FF", dout);
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h11) begin
            n_fails++;
            $display("FAIL bound_addr0: got %02h expected 11", dout);
        end
        drive(1'b0, 1'b0, 4'd1, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL bound_addr1: got %02h expected 00", dout);
        end
        drive(1'b0, 1'b0, 4'd14, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL bound_addr14: got %02h expected 00", dout);
        end
    endtask

    task automatic test_reset_clear();
        drive(1'b1, 1'b1, 4'd2, 8'h77);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL rst_with_write_dout: got %02h expected 00", dout);
        end
        drive(1'b0, 1'b0, 4'd2, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL rst_clear_addr2: got %02h expected 00", dout);
        end
        drive(1'b0, 1'b0, 4'd5, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL rst_clear_addr5: got %02h expected 00", dout);
        end
        drive(1'b0, 1'b0, 4'd7, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h00) begin
            n_fails++;
            $display("FAIL rst_clear_addr7: got %02h expected 00", dout);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 4'd5, 8'h3C);
        tick();
        drive(1'b0, 1'b1, 4'd9, 8'h96);
        tick();
        drive(1'b0, 1'b0, 4'd5, 8'h00);
        tick();
        n_checks++;
        if (dout !== 8'h3C) begin
            n_fails++;
            $display("FAIL hold_initial: got %02h expected 3C", dout);
        end
        // Wiggle inputs mid-cycle; dout must not react until the edge.
        #1 addr = 4'd9;
        #1 din = 8'hC3;
        #1 we = 1'b1;
        n_checks++;
        if (dout !== 8'h3C) begin
            n_fails++;
            $display("FAIL hold_between_edges: got %02h expected 3C", dout);
        end
        #1 we = 1'b0;
        n_checks++;
        if (dout !== 8'h3C) begin
            n_fails++;
            $display("FAIL hold_before_edge: got %02h expected 3C", dout);
        end
        tick();
        n_checks++;
        if (dout !== 8'h96) begin
            n_fails++;
            $display("FAIL hold_after_edge: got %02h expected 96", dout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'd3, 8'h10 + 8'(i));
            tick();
            drive(1'b0, 1'b0, 4'd3, 8'h00);
            tick();
            n_checks++;
            if (dout !== 8'h10 + 8'(i)) begin
                n_fails++;
                $display("FAIL b2b_iter%0d: got %02h expected %02h", i, dout, 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            tick();
            n_checks++;
            if (dout !== m_dout) begin
                n_fails++;
                $display("FAIL random_cycle%0d: got %02h expected %02h", i, dout, m_dout);
            end
        end
        // Final sweep confirms every stored word against the model.
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, a[3:0], 8'h00);
            tick();
            n_checks++;
            if (dout !== m_mem[a]) begin
                n_fails++;
                $display("FAIL random_sweep_addr%0d: got %02h expected %02h", a, dout, m_mem[a]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_dout   = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        #1;
        test_reset();
        test_basic();
        test_write_through();
        test_boundaries();
        test_reset_clear();
        test_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4: address width in bits.
REQ-003 The block SHALL have derived depth DEPTH = 2**ADDR_WIDTH, i.e. 16 words by default.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port we, input, 1 bit: write enable; 1 = write, 0 = read.
REQ-007 The block SHALL have port addr, input, ADDR_WIDTH bits: word address for both read and write.
REQ-008 The block SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-009 The block SHALL have port dout, output, DATA_WIDTH bits: registered read data.

Function
REQ-010 The block SHALL hold DEPTH words of DATA_WIDTH bits, with a single shared port.
REQ-011 When rst=0 and we=1, the block SHALL write din into mem[addr] at the rising clk edge.
REQ-012 When rst=0 and we=0, the block SHALL load mem[addr] into dout at the rising clk edge; read latency is 1 cycle and memory is unchanged.
REQ-013 When rst=0 and we=1, the block SHALL load din into dout in the same edge (write-first / write-through).
REQ-014 dout SHALL change only at rising clk edges; changes to addr, din or we between edges SHALL have no effect on dout.
REQ-015 All addresses 0..DEPTH-1 SHALL be valid; there is no wrap or out-of-range case, and address 0 and address DEPTH-1 SHALL behave identically to other addresses.
REQ-016 A write to one address SHALL leave every other address unchanged.
REQ-017 Back-to-back writes, reads, and write-then-read of the same address in consecutive cycles SHALL be supported with no stall; a read in the cycle after a write SHALL return the newly written data.
REQ-018 dout SHALL hold its last value while no clock edge occurs.
REQ-019 The design SHALL contain no combinational path from any input to dout.

Reset
REQ-020 When rst=1 at a rising clk edge, dout SHALL become 0.
REQ-021 When rst=1 at a rising clk edge, every memory word SHALL become 0.
REQ-022 rst SHALL take priority over we: a write asserted in a reset cycle SHALL be discarded.
REQ-023 Reset asserted mid-operation SHALL take effect at the next edge, and normal operation SHALL resume on the first edge with rst=0.
REQ-024 Reads of any address after reset and before any write SHALL return 0.

Verification
REQ-025 Basic write/read: rst for 2 cycles, then we=1 addr=2 din=A5, then we=1 addr=5 din=3C, then we=0 addr=2, then we=0 addr=5 -> dout=A5 after the 3rd post-reset edge and dout=3C after the 4th.
REQ-026 Write-through: we=1 addr=7 din=5A -> dout=5A after that edge; then we=0 addr=7 -> dout=5A.
REQ-027 Boundaries: write 11 to addr 0 and FF to addr 15, then read addr 15 and addr 0 -> FF then 11; addr 1 and addr 14 still read 00.
REQ-028 Reset clear: after REQ-025, assert rst=1 with we=1 addr=2 din=77 -> dout=00; after reset, read addr 2 -> 00 and read addr 5 -> 00.
REQ-029 Hold: with we=0 addr=5, change addr between edges -> dout changes only at the next rising edge.
REQ-030 Random: 200 random we/addr/din cycles checked against a reference memory model using the rules REQ-011..REQ-013 -> no mismatches.
